area_to_radius: RTL and testbench

- Inverse of the radius-to-area datapath: accepts a signed area word and returns the radius that produced it.
- Computes radius = isqrt((area * INV_K) >> 16), where INV_K is the Q16.16 reciprocal of the forward path's area constant.
- Bit-serial, one root bit per cycle; one multiplier, no vendor IP.
- Sits downstream of the area producer for loop-back checking and calibration.

---
 rtl/area_to_radius_pkg.sv | 11 +
 rtl/isqrt_step.sv | 21 ++
 rtl/area_to_radius.sv | 86 ++++++++
 tb/tb_area_to_radius.sv | 115 +++++++++++
 4 files changed

// File: rtl/area_to_radius_pkg.sv
// area_to_radius_pkg: shared widths, state encoding and counter sizing for area_to_radius
package area_to_radius_pkg;
  localparam int AREA_W_DEF = 26;
  localparam int RAD_W_DEF = 16;
  localparam logic [31:0] INV_K_ONE = 32'd65536;
  localparam int CNT_W_DEF = $clog2(RAD_W_DEF + 1);
  typedef enum logic [1:0] {IDLE, SCALE, ITER, DONE} state_t;
  function automatic int cnt_w(input int rad_w);
    return $clog2(rad_w + 1);
  endfunction
endpackage

// File: rtl/isqrt_step.sv
// isqrt_step: one MSB-first digit of the integer square root (bring down 2 bits, trial subtract)
module isqrt_step #(
  parameter int RAD_W = 16
) (
  input  logic [RAD_W+1:0] rem,
  input  logic [RAD_W-1:0] root,
  input  logic [1:0]       bits,
  output logic [RAD_W+1:0] rem_next,
  output logic [RAD_W-1:0] root_next
);
  logic [RAD_W+1:0] acc;
  logic [RAD_W+1:0] trial;
  logic fit;
  always_comb begin
    acc = (rem << 2) | {{RAD_W{1'b0}}, bits};
    trial = {root, 2'b01};
    fit = acc >= trial;
    rem_next = fit ? acc - trial : acc;
    root_next = (root << 1) | {{(RAD_W-1){1'b0}}, fit};
  end
endmodule

// File: rtl/area_to_radius.sv
// area_to_radius: bit-serial radius = isqrt((area*INV_K)>>16); AREA_TO_RADIUS_ROUND_EN enables round-to-nearest
module area_to_radius
  import area_to_radius_pkg::*;
#(
  parameter int          AREA_W = AREA_W_DEF,
  parameter int          RAD_W  = RAD_W_DEF,
  parameter logic [31:0] INV_K  = INV_K_ONE
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [AREA_W-1:0] area,
  output logic              busy,
  output logic [RAD_W-1:0]  radius,
  output logic              rdy
);
  localparam int OP_W = 2 * RAD_W;
  localparam int REM_W = RAD_W + 2;
  localparam int CNT_W = cnt_w(RAD_W);
  localparam int PROD_W = AREA_W + 32;
  state_t state, state_n;
  logic [AREA_W-1:0] area_q;
  logic [OP_W-1:0] op;
  logic [REM_W-1:0] rem, rem_n;
  logic [RAD_W-1:0] root, root_n, res;
  logic [CNT_W-1:0] cnt;
  logic [PROD_W-1:0] prod, p;
  logic sat, last;
  assign prod = PROD_W'(area_q) * PROD_W'(INV_K);
  assign p = prod >> 16;
  assign sat = p > PROD_W'({OP_W{1'b1}});
  assign last = cnt == CNT_W'(RAD_W - 1);
  assign busy = state != IDLE;
  assign rdy = state == DONE;
  isqrt_step #(.RAD_W(RAD_W)) u_step (
    .rem(rem),
    .root(root),
    .bits(op[OP_W-1 -: 2]),
    .rem_next(rem_n),
    .root_next(root_n)
  );
`ifdef AREA_TO_RADIUS_ROUND_EN
  // leftover rem > root means sqrt(p) >= root + 0.5
  assign res = (REM_W'(root_n) < rem_n && !(&root_n)) ? root_n + 1'b1 : root_n;
`else
  assign res = root_n;
`endif
  always_comb begin
    state_n = state;
    case (state)
      IDLE:  state_n = en ? SCALE : IDLE;
      SCALE: state_n = ITER;
      ITER:  state_n = last ? DONE : ITER;
      DONE:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  // radius loads on the last root digit so it is already valid while rdy is high
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      area_q <= '0;
      op <= '0;
      rem <= '0;
      root <= '0;
      cnt <= '0;
      radius <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && en) area_q <= area[AREA_W-1] ? '0 : area;
      if (state == SCALE) begin
        op <= sat ? '1 : p[OP_W-1:0];
        rem <= '0;
        root <= '0;
        cnt <= '0;
      end
      if (state == ITER) begin
        op <= op << 2;
        rem <= rem_n;
        root <= root_n;
        cnt <= cnt + 1'b1;
        if (last) radius <= res;
      end
    end
  end
endmodule

// File: tb/tb_area_to_radius.sv
// tb_area_to_radius: directed vectors on unity and saturating-scale instances
module tb_area_to_radius;
  typedef struct {
    logic [25:0] area;
    logic [15:0] f1, n1, f2, n2;
    bit poke;
  } vec_t;
`ifdef AREA_TO_RADIUS_ROUND_EN
  localparam bit RND = 1'b1;
`else
  localparam bit RND = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b0, en = 1'b0;
  logic [25:0] area = '0;
  logic busy1, rdy1, busy2, rdy2;
  logic [15:0] radius1, radius2;
  int checks = 0, errors = 0;
  vec_t vecs[11];
  always #5 clk = ~clk;
  area_to_radius u_dut (
    .clk(clk), .rst(rst), .en(en), .area(area),
    .busy(busy1), .radius(radius1), .rdy(rdy1)
  );
  area_to_radius #(.INV_K(32'h80000000)) u_sat (
    .clk(clk), .rst(rst), .en(en), .area(area),
    .busy(busy2), .radius(radius2), .rdy(rdy2)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", name, act, exp);
    end
  endtask
  task automatic run(input logic [25:0] a, input bit poke, input logic [15:0] e1, input logic [15:0] e2);
    int hit = -1;
    int bad = 0;
    logic [15:0] r1 = 'x, r2 = 'x;
    @(negedge clk);
    area = a;
    en = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 22; c++) begin
      @(negedge clk);
      if (c == 1) begin
        en = 1'b0;
        area = 26'h1234;
      end
      if (poke && c == 5) begin
        en = 1'b1;
        area = 26'd400;
      end
      if (c == 6) en = 1'b0;
      if (busy1 !== (c <= 18) || busy2 !== (c <= 18)) bad++;
      if (rdy1 !== rdy2) bad++;
      if (rdy1 === 1'b1) begin
        if (hit < 0) hit = c;
        else bad++;
        r1 = radius1;
        r2 = radius2;
      end
    end
    chk($sformatf("rdy_cycle a=%0d", a), hit, 18);
    chk($sformatf("busy_rdy_pattern a=%0d", a), bad, 0);
    chk($sformatf("radius a=%0d", a), r1, e1);
    chk($sformatf("radius_sat a=%0d", a), r2, e2);
    chk($sformatf("radius_hold a=%0d", a), radius1, e1);
  endtask
  initial begin
    int seen;
    vecs[0]  = '{26'd0,        16'd0,    16'd0,    16'd0,     16'd0,     1'b0};
    vecs[1]  = '{26'd1,        16'd1,    16'd1,    16'd181,   16'd181,   1'b0};
    vecs[2]  = '{26'd2,        16'd1,    16'd1,    16'd256,   16'd256,   1'b0};
    vecs[3]  = '{26'd3,        16'd1,    16'd2,    16'd313,   16'd314,   1'b0};
    vecs[4]  = '{26'd144,      16'd12,   16'd12,   16'd2172,  16'd2172,  1'b0};
    vecs[5]  = '{26'd10000,    16'd100,  16'd100,  16'd18101, 16'd18102, 1'b1};
    vecs[6]  = '{26'd10200,    16'd100,  16'd101,  16'd18282, 16'd18282, 1'b0};
    vecs[7]  = '{26'd400,      16'd20,   16'd20,   16'd3620,  16'd3620,  1'b0};
    vecs[8]  = '{26'h3FFFFFB,  16'd0,    16'd0,    16'd0,     16'd0,     1'b0};
    vecs[9]  = '{26'h1FFFFFF,  16'd5792, 16'd5793, 16'd65535, 16'd65535, 1'b0};
    vecs[10] = '{26'd1000000,  16'd1000, 16'd1000, 16'd65535, 16'd65535, 1'b0};
    repeat (2) @(negedge clk);
    chk("reset_busy", {busy1, busy2}, 0);
    chk("reset_rdy", {rdy1, rdy2}, 0);
    chk("reset_radius", {radius1, radius2}, 0);
    rst = 1'b1;
    foreach (vecs[i])
      run(vecs[i].area, vecs[i].poke, RND ? vecs[i].n1 : vecs[i].f1, RND ? vecs[i].n2 : vecs[i].f2);
    // abort a computation with an asynchronous reset mid-ITER
    @(negedge clk);
    area = 26'd10000;
    en = 1'b1;
    @(posedge clk);
    @(negedge clk);
    en = 1'b0;
    repeat (8) @(negedge clk);
    chk("pre_abort_busy", busy1, 1);
    #2 rst = 1'b0;
    #1;
    chk("abort_busy", {busy1, busy2}, 0);
    chk("abort_radius", {radius1, radius2}, 0);
    chk("abort_rdy", {rdy1, rdy2}, 0);
    @(negedge clk);
    rst = 1'b1;
    seen = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (rdy1 !== 1'b0 || rdy2 !== 1'b0 || busy1 !== 1'b0) seen++;
    end
    chk("abort_no_rdy", seen, 0);
    run(26'd144, 1'b0, 16'd12, 16'd2172);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
